// File: rtl/dmem_arb_if.sv
// Shared data-memory bus: two requesters (core, debug) plus the memory side.
// The arbiter takes the slave view; whoever drives requests and memory data takes master.
interface dmem_arb_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic                m0_req;
    logic                m0_we;
    logic [ADDR_W-1:0]   m0_addr;
    logic [DATA_W-1:0]   m0_wdata;
    logic [DATA_W/8-1:0] m0_wstrb;
    logic                m0_gnt;
    logic                m0_rvalid;
    logic [DATA_W-1:0]   m0_rdata;

    logic                m1_req;
    logic                m1_we;
    logic [ADDR_W-1:0]   m1_addr;
    logic [DATA_W-1:0]   m1_wdata;
    logic [DATA_W/8-1:0] m1_wstrb;
    logic                m1_lock;
    logic                m1_gnt;
    logic                m1_rvalid;
    logic [DATA_W-1:0]   m1_rdata;

    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_lock,
        input  mem_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_lock,
        output mem_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/dmem_arb.sv
// Data-memory arbiter: core (port 0) fixed priority, debug (port 1) anti-starvation.
// Optional exclusive debug bursts when DMEM_ARB_LOCK_EN is defined.
module dmem_arb #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    dmem_arb_if.slave bus
);
    logic [3:0] starve;
    logic [1:0] rd_own;
    logic       force1;
    logic       lock_act;
    logic       g0;
    logic       g1;

    assign force1 = (starve == 4'(STARVE_MAX));

`ifdef DMEM_ARB_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state;

    // The cycle m1_lock drops already arbitrates normally
    assign lock_act = (state == LOCKED) && bus.m1_lock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (g1 && bus.m1_lock) state <= LOCKED;
                LOCKED:  if (!bus.m1_lock)      state <= IDLE;
                default:                        state <= IDLE;
            endcase
        end
    end
`else
    logic unused_lock;
    assign unused_lock = bus.m1_lock;
    assign lock_act    = 1'b0;
`endif

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst_n) begin
            g0 = 1'b0;
            g1 = 1'b0;
        end else if (lock_act) begin
            g1 = bus.m1_req;
        end else if (force1 && bus.m1_req) begin
            g1 = 1'b1;
        end else begin
            g0 = bus.m0_req;
            g1 = bus.m1_req & ~bus.m0_req;
        end
    end

    assign bus.m0_gnt = g0;
    assign bus.m1_gnt = g1;

    always_comb begin
        bus.mem_en    = g0 | g1;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        if (g0) begin
            bus.mem_we    = bus.m0_we;
            bus.mem_addr  = bus.m0_addr;
            bus.mem_wdata = bus.m0_wdata;
            bus.mem_wstrb = bus.m0_wstrb;
        end else if (g1) begin
            bus.mem_we    = bus.m1_we;
            bus.mem_addr  = bus.m1_addr;
            bus.mem_wdata = bus.m1_wdata;
            bus.mem_wstrb = bus.m1_wstrb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
            rd_own <= '0;
        end else begin
            rd_own <= {g1 & ~bus.m1_we, g0 & ~bus.m0_we};
            if (lock_act)
                starve <= '0;
            else if (bus.m1_req && !g1)
                starve <= starve + 4'd1;
            else
                starve <= '0;
        end
    end

    assign bus.m0_rvalid = rd_own[0];
    assign bus.m1_rvalid = rd_own[1];
    assign bus.m0_rdata  = rd_own[0] ? bus.mem_rdata : '0;
    assign bus.m1_rdata  = rd_own[1] ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb with a small behavioural data memory.
module tb_dmem_arb;
    logic clk;
    logic rst_n;
    logic preload;
    int   checks;
    int   failures;

    dmem_arb_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    dmem_arb #(.ADDR_W(12), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];

    always @(posedge clk) begin
        if (preload) begin
            mem[12'h010] <= 32'hDEADBEEF;
            mem[12'h020] <= 32'hAAAAAAAA;
            mem[12'h001] <= 32'h11111111;
            mem[12'h002] <= 32'h22222222;
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wstrb[b])
                        mem[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
            end else begin
                bus.mem_rdata <= mem[bus.mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0;
        bus.m0_wdata = '0; bus.m0_wstrb = '0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0;
        bus.m1_wdata = '0; bus.m1_wstrb = '0; bus.m1_lock = 0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 0;
        preload = 1;
        bus.mem_rdata = '0;
        idle_all();
        #2;
        chk("rst_m0_gnt", 32'(bus.m0_gnt), 0);
        chk("rst_m1_gnt", 32'(bus.m1_gnt), 0);
        chk("rst_mem_en", 32'(bus.mem_en), 0);
        chk("rst_rvalid", 32'({bus.m1_rvalid, bus.m0_rvalid}), 0);
        chk("rst_m0_rdata", bus.m0_rdata, 0);
        cyc();
        cyc();
        preload = 0;
        rst_n = 1;
        cyc();

        // Port 0 read
        bus.m0_req = 1; bus.m0_addr = 12'h010;
        #1;
        chk("p0rd_gnt", 32'(bus.m0_gnt), 1);
        chk("p0rd_m1_gnt", 32'(bus.m1_gnt), 0);
        chk("p0rd_mem_en", 32'(bus.mem_en), 1);
        chk("p0rd_mem_addr", 32'(bus.mem_addr), 32'h010);
        cyc();
        chk("p0rd_rvalid", 32'(bus.m0_rvalid), 1);
        chk("p0rd_rdata", bus.m0_rdata, 32'hDEADBEEF);
        chk("p0rd_m1_rvalid", 32'(bus.m1_rvalid), 0);
        bus.m0_req = 0;
        cyc();
        chk("p0rd_rvalid_off", 32'(bus.m0_rvalid), 0);
        chk("p0rd_rdata_off", bus.m0_rdata, 0);

        // Continuous contention: 4 core grants then 1 debug grant
        bus.m0_req = 1; bus.m0_addr = 12'h001;
        bus.m1_req = 1; bus.m1_addr = 12'h002;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("starve_g0_%0d", i), 32'(bus.m0_gnt), (i % 5 != 4) ? 1 : 0);
            chk($sformatf("starve_g1_%0d", i), 32'(bus.m1_gnt), (i % 5 == 4) ? 1 : 0);
            cyc();
            if (i % 5 != 4) begin
                chk($sformatf("starve_rv0_%0d", i), 32'(bus.m0_rvalid), 1);
                chk($sformatf("starve_rd0_%0d", i), bus.m0_rdata, 32'h11111111);
                chk($sformatf("starve_rv1_%0d", i), 32'(bus.m1_rvalid), 0);
            end else begin
                chk($sformatf("starve_rv1_%0d", i), 32'(bus.m1_rvalid), 1);
                chk($sformatf("starve_rd1_%0d", i), bus.m1_rdata, 32'h22222222);
                chk($sformatf("starve_rv0_%0d", i), 32'(bus.m0_rvalid), 0);
            end
        end
        idle_all();
        cyc();

        // Port 1 partial write, then port 0 read-back
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 12'h020;
        bus.m1_wdata = 32'h12345678; bus.m1_wstrb = 4'b0011;
        #1;
        chk("wr_m1_gnt", 32'(bus.m1_gnt), 1);
        chk("wr_mem_we", 32'(bus.mem_we), 1);
        chk("wr_mem_wstrb", 32'(bus.mem_wstrb), 32'h3);
        chk("wr_mem_wdata", bus.mem_wdata, 32'h12345678);
        cyc();
        chk("wr_no_rvalid", 32'({bus.m1_rvalid, bus.m0_rvalid}), 0);
        idle_all();
        bus.m0_req = 1; bus.m0_addr = 12'h020;
        cyc();
        chk("rb_rvalid", 32'(bus.m0_rvalid), 1);
        chk("rb_rdata", bus.m0_rdata, 32'hAAAA5678);
        idle_all();

        // Alternating reads, data must not cross ports
        bus.m0_req = 1; bus.m0_addr = 12'h001;
        cyc();
        chk("alt0_rv0", 32'(bus.m0_rvalid), 1);
        chk("alt0_rd0", bus.m0_rdata, 32'h11111111);
        chk("alt0_rd1", bus.m1_rdata, 0);
        bus.m0_req = 0; bus.m1_req = 1; bus.m1_addr = 12'h002;
        cyc();
        chk("alt1_rv1", 32'(bus.m1_rvalid), 1);
        chk("alt1_rd1", bus.m1_rdata, 32'h22222222);
        chk("alt1_rv0", 32'(bus.m0_rvalid), 0);
        chk("alt1_rd0", bus.m0_rdata, 0);
        bus.m1_req = 0; bus.m0_req = 1; bus.m0_addr = 12'h010;
        cyc();
        chk("alt2_rv0", 32'(bus.m0_rvalid), 1);
        chk("alt2_rd0", bus.m0_rdata, 32'hDEADBEEF);
        chk("alt2_rv1", 32'(bus.m1_rvalid), 0);
        idle_all();
        cyc();

`ifdef DMEM_ARB_LOCK_EN
        // Locked debug burst blocks the core
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_lock = 1;
        bus.m1_addr = 12'h030; bus.m1_wdata = 32'h1; bus.m1_wstrb = 4'hF;
        #1;
        chk("lk_first_g1", 32'(bus.m1_gnt), 1);
        cyc();
        bus.m0_req = 1; bus.m0_addr = 12'h010;
        for (int i = 0; i < 3; i++) begin
            bus.m1_addr = 12'h031 + 12'(i);
            #1;
            chk($sformatf("lk_g0_%0d", i), 32'(bus.m0_gnt), 0);
            chk($sformatf("lk_g1_%0d", i), 32'(bus.m1_gnt), 1);
            cyc();
        end
        bus.m1_lock = 0; bus.m1_req = 0; bus.m1_we = 0;
        #1;
        chk("lk_drop_g0", 32'(bus.m0_gnt), 1);
        cyc();
        idle_all();
        cyc();
`endif

        // Reset during a pending read
        bus.m0_req = 1; bus.m0_addr = 12'h010;
        #1;
        chk("rr_gnt", 32'(bus.m0_gnt), 1);
        @(posedge clk);
        #1;
        rst_n = 0;
        idle_all();
        #1;
        chk("rr_rv_in_rst", 32'({bus.m1_rvalid, bus.m0_rvalid}), 0);
        chk("rr_rd0_in_rst", bus.m0_rdata, 0);
        chk("rr_mem_en_in_rst", 32'(bus.mem_en), 0);
        cyc();
        rst_n = 1;
        cyc();
        chk("rr_rv_after", 32'({bus.m1_rvalid, bus.m0_rvalid}), 0);
        chk("rr_rd0_after", bus.m0_rdata, 0);
        chk("rr_gnt_after", 32'({bus.m1_gnt, bus.m0_gnt}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
